mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: widths, FSM encoding
// and the small length helpers used by the load/store path.
package mem_ctrl_pkg;
  localparam int ADDR_WID        = 32;
  localparam int ICACHE_LINE_WID = 512;
  localparam int LINE_BYTES      = 64;
  localparam int CNT_WID         = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_t;

  // ls_len encodes 1/2/4 bytes; the unused code is treated as a word.
  function automatic logic [CNT_WID-1:0] ls_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 7'd1;
      2'd1:    return 7'd2;
      default: return 7'd4;
    endcase
  endfunction

  function automatic logic [31:0] zext_load(input logic [31:0] w, input logic [CNT_WID-1:0] n);
    case (n)
      7'd1:    return {24'd0, w[7:0]};
      7'd2:    return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter for instruction-line fetches and LSB loads/stores.
// RAM has one cycle of read latency; the LSB always wins arbitration over IFetch.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       io_buffer_full,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [ADDR_WID-1:0]        mem_a,
  output logic                       mem_wr,
  input  logic                       if_en,
  input  logic [ADDR_WID-1:0]        if_pc,
  output logic                       if_done,
  output logic [ICACHE_LINE_WID-1:0] if_data,
  input  logic                       ls_en,
  input  logic                       ls_wr,
  input  logic [ADDR_WID-1:0]        ls_addr,
  input  logic [1:0]                 ls_len,
  input  logic [31:0]                ls_wdata,
  output logic                       ls_done,
  output logic [31:0]                ls_rdata
);
  state_t                     state;
  logic [CNT_WID-1:0]         cnt;
  logic [CNT_WID-1:0]         xfer_len;
  logic [CNT_WID-1:0]         cnt_inc;
  logic [5:0]                 rd_idx;
  logic [ICACHE_LINE_WID-1:0] line_buf;
  logic [ICACHE_LINE_WID-1:0] buf_nxt;
  logic                       uart_stall;

  assign cnt_inc    = cnt + 7'd1;
  assign rd_idx     = 6'(cnt - 7'd1);
  assign uart_stall = io_buffer_full && (ls_addr[17:16] == 2'b11);

  // mem_din seen while cnt=k belongs to byte k-1 (address was issued one cycle earlier)
  always_comb begin
    buf_nxt = line_buf;
    if (cnt != '0) buf_nxt[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      xfer_len <= '0;
      line_buf <= '0;
      mem_a    <= '0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: begin
          // the requester still holds its level enable during the done cycle
          if (!if_done && !ls_done) begin
            if (ls_en) begin
              if (ls_wr) begin
                state    <= LS_WR;
                xfer_len <= ls_bytes(ls_len);
                mem_a    <= ls_addr;
                mem_dout <= ls_wdata[7:0];
                mem_wr   <= !uart_stall;
              end else if (!rollback) begin
                state    <= LS_RD;
                xfer_len <= ls_bytes(ls_len);
                mem_a    <= ls_addr;
              end
            end else if (if_en && !rollback) begin
              state    <= IF_RD;
              xfer_len <= 7'(LINE_BYTES);
              mem_a    <= if_pc;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (rollback) begin
            state <= IDLE;
            cnt   <= '0;
            mem_a <= '0;
          end else begin
            line_buf <= buf_nxt;
            if (cnt == xfer_len) begin
              state <= IDLE;
              cnt   <= '0;
              mem_a <= '0;
              if (state == IF_RD) begin
                if_done <= 1'b1;
                if_data <= buf_nxt;
              end else begin
                ls_done  <= 1'b1;
                ls_rdata <= zext_load(buf_nxt[31:0], xfer_len);
              end
            end else begin
              cnt   <= cnt_inc;
              mem_a <= (cnt_inc == xfer_len) ? '0 : mem_a + 32'd1;
            end
          end
        end
        LS_WR: begin
          // mem_wr=1 means byte cnt is being written now; 0 means it is still pending
          if (mem_wr) begin
            if (cnt_inc == xfer_len) begin
              state    <= IDLE;
              cnt      <= '0;
              mem_a    <= '0;
              mem_dout <= '0;
              mem_wr   <= 1'b0;
              ls_done  <= 1'b1;
            end else begin
              cnt      <= cnt_inc;
              mem_a    <= mem_a + 32'd1;
              mem_dout <= ls_wdata[{2'(cnt_inc), 3'b000} +: 8];
              mem_wr   <= !uart_stall;
            end
          end else begin
            mem_wr <= !uart_stall;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized transfers
// checked against a byte-addressed reference memory.
module tb_mem_ctrl;
  logic         clk = 1'b0;
  logic         rst, rdy, rollback, io_buffer_full;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         if_en;
  logic [31:0]  if_pc;
  logic         if_done;
  logic [511:0] if_data;
  logic         ls_en, ls_wr;
  logic [31:0]  ls_addr;
  logic [1:0]   ls_len;
  logic [31:0]  ls_wdata;
  logic         ls_done;
  logic [31:0]  ls_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram     [int unsigned];
  logic [7:0] ref_mem [int unsigned];
  logic [511:0] last_line = '0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .if_en(if_en), .if_pc(if_pc), .if_done(if_done), .if_data(if_data),
    .ls_en(ls_en), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Synchronous RAM: one cycle read latency, write on mem_wr
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0=IF line read, 1=LSB load, 2=LSB store; frz = cycles of rdy=0 starting at cycle 1
  task automatic xfer(input int kind, input logic [31:0] addr, input logic [1:0] len,
                      input logic [31:0] wdata, input int frz, input string tag);
    int n, exp_lat, done_cyc, wr_cycles, bad_addr;
    logic [511:0] exp_data, got;
    n = (kind == 0) ? 64 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    exp_lat = ((kind == 2) ? n + 1 : n + 2) + frz;
    exp_data = '0;
    for (int k = 0; k < n; k++) begin
      if (kind == 2) ref_mem[addr + k] = wdata[8*k +: 8];
      else exp_data[8*k +: 8] = ref_rd(addr + k);
    end
    if (kind == 0) begin
      if_en = 1'b1; if_pc = addr;
    end else begin
      ls_en = 1'b1; ls_wr = (kind == 2); ls_addr = addr; ls_len = len; ls_wdata = wdata;
    end
    done_cyc = -1; wr_cycles = 0; bad_addr = 0;
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      tick();
      if (cyc <= n && mem_a !== addr + cyc - 1) bad_addr++;
      if (mem_wr) wr_cycles++;
      if ((kind == 0) ? if_done : ls_done) done_cyc = cyc;
      if (cyc == 1 && frz > 0) rdy = 1'b0;
      if (cyc == 1 + frz) rdy = 1'b1;
    end
    if_en = 1'b0; ls_en = 1'b0; rdy = 1'b1;
    check({tag, " latency"}, done_cyc, exp_lat);
    if (kind == 2) begin
      got = '0; exp_data = '0;
      for (int k = 0; k < n; k++) begin
        got[8*k +: 8] = ram_rd(addr + k);
        exp_data[8*k +: 8] = wdata[8*k +: 8];
      end
      check({tag, " stored bytes"}, got, exp_data);
    end else if (kind == 0) begin
      check({tag, " if_data"}, if_data, exp_data);
      last_line = exp_data;
    end else begin
      check({tag, " ls_rdata"}, ls_rdata, exp_data);
    end
    if (frz == 0) begin
      check({tag, " addr seq"}, bad_addr, 0);
      check({tag, " wr cycles"}, wr_cycles, (kind == 2) ? n : 0);
    end
    tick();
    check({tag, " done one cycle"}, {if_done, ls_done}, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, cnt_bad;
    logic [31:0] exp_w;
    logic [511:0] exp_l;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_pc = '0; ls_en = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset mem_a", mem_a, 0);
    check("reset ctrl", {mem_wr, mem_dout, if_done, ls_done}, 0);
    check("reset data", {if_data, ls_rdata}, 0);
    tick();

    // line read: byte k of 0x1000 line is k
    xfer(0, 32'h1000, 2'd0, 32'h0, 0, "if 0x1000");
    for (int k = 0; k < 64; k++) exp_l[8*k +: 8] = 8'(k);
    check("if 0x1000 pattern", if_data, exp_l);

    // simultaneous requests: LSB load first, IF no earlier than cycle 7
    exp_w = {ref_rd(32'h2005), ref_rd(32'h2004), ref_rd(32'h2003), ref_rd(32'h2002)};
    for (int k = 0; k < 64; k++) exp_l[8*k +: 8] = ref_rd(32'h1040 + k);
    ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2002; ls_len = 2'd2; if_en = 1'b1; if_pc = 32'h1040;
    dc = -1;
    for (int cyc = 1; cyc <= 20 && dc < 0; cyc++) begin
      tick();
      if (ls_done) dc = cyc;
    end
    ls_en = 1'b0;
    check("prio ls latency", dc, 6);
    check("prio ls_rdata", ls_rdata, exp_w);
    tick();
    check("prio if not granted by 7", mem_a, 0);
    dc = -1;
    for (int cyc = 8; cyc <= 200 && dc < 0; cyc++) begin
      tick();
      if (if_done) dc = cyc;
    end
    if_en = 1'b0;
    check("prio if done after", dc >= 73, 1'b1);
    check("prio if_data", if_data, exp_l);
    last_line = exp_l;
    tick();

    // two-byte store, little-endian
    xfer(2, 32'h30, 2'd1, 32'h0000BEEF, 0, "store beef");
    check("store beef bytes", {ram_rd(32'h31), ram_rd(32'h30)}, 16'hBEEF);

    // UART-region store stalled by io_buffer_full
    io_buffer_full = 1'b1;
    ls_en = 1'b1; ls_wr = 1'b1; ls_addr = 32'h30000; ls_len = 2'd0; ls_wdata = 32'h5A;
    ref_mem[32'h30000] = 8'h5A;
    cnt_bad = 0; dc = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (mem_wr && cyc <= 5) cnt_bad++;
      if (mem_wr) dc += 100;
      if (ls_done) begin
        dc++;
        ls_en = 1'b0;
      end
      if (cyc == 5) io_buffer_full = 1'b0;
    end
    check("uart no write in stall", cnt_bad, 0);
    check("uart one write one done", dc, 101);
    check("uart byte", ram_rd(32'h30000), 8'h5A);

    // rollback in IDLE blocks loads and fetches
    rollback = 1'b1; ls_en = 1'b1; ls_wr = 1'b0; ls_addr = 32'h2000; ls_len = 2'd2; if_en = 1'b1;
    repeat (3) tick();
    check("rollback idle no grant", mem_a, 0);
    ls_en = 1'b0; if_en = 1'b0;
    tick();
    // store granted and completed under rollback
    xfer(2, 32'h4010, 2'd2, 32'hCAFEF00D, 0, "store rollback");
    rollback = 1'b0;

    // rollback at cycle 20 of a line read
    if_en = 1'b1; if_pc = 32'h1000;
    repeat (20) tick();
    check("rb mid addr", mem_a, 32'h1000 + 19);
    rollback = 1'b1; if_en = 1'b0;
    tick();
    rollback = 1'b0;
    check("rb idle cycle 21", mem_a, 0);
    dc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      tick();
      if (if_done) dc++;
    end
    check("rb no if_done", dc, 0);
    check("rb if_data held", if_data, last_line);

    // asynchronous reset mid-read
    if_en = 1'b1; if_pc = 32'h1000;
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    check("arst mem_a", mem_a, 0);
    check("arst data", {if_data, ls_rdata, mem_wr, if_done}, 0);
    if_en = 1'b0;
    tick();
    rst = 1'b0;
    dc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      tick();
      if (if_done || ls_done) dc++;
    end
    check("arst no done", dc, 0);

    // randomized traffic against the reference memory
    for (int i = 0; i < 24; i++) begin
      int kind, frz;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = (kind == 0) ? 32'h4000 + 64 * $urandom_range(0, 3) : 32'h4000 + $urandom_range(0, 255);
      frz = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      xfer(kind, a, 2'($urandom_range(0, 2)), $urandom, frz, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
